// File: rtl/sdram_read_to_avalon_st.sv
// Instruction-driven Avalon-MM burst reader that streams returned words out on an Avalon-ST source.
// Define SDRAM_READ_ST_LAST_EN to add st_last, flagging the final word of each instruction.
module sdram_read_to_avalon_st #(
    parameter int MAX_BURST  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         st_instruction_valid,
    output logic         st_instruction_ready,
    input  logic [31:0]  st_instruction_data,
    output logic [26:0]  mm_addr,
    output logic [7:0]   mm_burstcount,
    output logic         mm_read,
    input  logic         mm_waitrequest,
    input  logic [255:0] mm_readdata,
    input  logic         mm_readdatavalid,
    output logic         st_valid,
    input  logic         st_ready,
`ifdef SDRAM_READ_ST_LAST_EN
    output logic         st_last,
`endif
    output logic [255:0] st_data
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef SDRAM_READ_ST_LAST_EN
    localparam int FIFO_W = 257;
`else
    localparam int FIFO_W = 256;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_next;

    logic [21:0]       addr;
    logic [10:0]       tx_rem, rx_rem, outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FIFO_W-1:0] mem [FIFO_DEPTH];
    logic [FIFO_W-1:0] head;

    logic [10:0] len, instr_count;
    logic [11:0] credit;
    logic        start, issue, accept, push, pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ISSUE;
            ISSUE:   if (accept && (tx_rem == len)) state_next = DRAIN;
            DRAIN:   if (rx_rem == 11'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Credit counts both words already buffered and words still in flight, so the FIFO can never overflow.
    always_comb begin
        instr_count = (st_instruction_data[9:0] == 10'd0) ? 11'd1024 : {1'b0, st_instruction_data[9:0]};
        len         = (tx_rem > 11'(MAX_BURST)) ? 11'(MAX_BURST) : tx_rem;
        credit      = 12'(FIFO_DEPTH) - 12'(fifo_count) - {1'b0, outstanding};
        start       = (state == IDLE) && st_instruction_ready && st_instruction_valid;
        issue       = (state == ISSUE) && !mm_read && (credit >= {1'b0, len});
        accept      = mm_read && !mm_waitrequest;
        push        = mm_readdatavalid && (outstanding != 11'd0);
        pop         = st_valid && st_ready;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_instruction_ready <= 1'b0;
            mm_read              <= 1'b0;
            mm_addr              <= '0;
            mm_burstcount        <= '0;
            addr                 <= '0;
            tx_rem               <= '0;
            rx_rem               <= '0;
            outstanding          <= '0;
        end else begin
            st_instruction_ready <= (state_next == IDLE);
            if (start) begin
                addr   <= st_instruction_data[31:10];
                tx_rem <= instr_count;
                rx_rem <= instr_count;
            end
            if (issue) begin
                mm_read       <= 1'b1;
                mm_addr       <= {addr, 5'b0};
                mm_burstcount <= len[7:0];
            end else if (accept) begin
                mm_read <= 1'b0;
                addr    <= addr + 22'(len);
                tx_rem  <= tx_rem - len;
            end
            outstanding <= outstanding + (accept ? len : 11'd0) - 11'(push);
            if (push) rx_rem <= rx_rem - 11'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage is left unreset; reset empties the FIFO through the pointers and count.
    always_ff @(posedge clock) begin
`ifdef SDRAM_READ_ST_LAST_EN
        if (push) mem[wr_ptr] <= {(rx_rem == 11'd1), mm_readdata};
`else
        if (push) mem[wr_ptr] <= mm_readdata;
`endif
    end

    assign head     = mem[rd_ptr];
    assign st_valid = (fifo_count != '0);
    assign st_data  = st_valid ? head[255:0] : '0;
`ifdef SDRAM_READ_ST_LAST_EN
    assign st_last  = st_valid ? head[256] : 1'b0;
`endif

endmodule

// File: doc/sdram_read_to_avalon_st.md
# sdram_read_to_avalon_st

Read-side counterpart of the SDRAM write path: accepts 32-bit read instructions, issues Avalon-MM burst reads to SDRAM, and streams the returned 256-bit words out on an Avalon-ST source. It sits between the SDRAM controller's read port and the accelerator's data-consuming stream (activation/weight fetch). An internal FIFO absorbs `mm_readdatavalid`, which cannot be back-pressured. Bursts are issued only when FIFO space is reserved for every requested word.

## Interface
- `MAX_BURST`, 8: maximum words per Avalon-MM burst, 1..128.
- `FIFO_DEPTH`, 16: return FIFO depth in words; power of 2, at least `MAX_BURST`.
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `st_instruction_valid` in 1, `st_instruction_ready` out 1, `st_instruction_data` in 32: instruction sink. `[31:10]` is the start word address; `[9:0]` is the word count, where 0 means 1024.
- `mm_addr` out 27: byte address equal to `{word_addr, 5'b0}`.
- `mm_burstcount` out 8: words in the current burst.
- `mm_read` out 1: read request.
- `mm_waitrequest` in 1: controller stall.
- `mm_readdata` in 256, `mm_readdatavalid` in 1: returned data.
- `st_valid` out 1, `st_ready` in 1, `st_data` out 256: data source.

## Operation
- **Reset values:**
  - `st_instruction_ready`=0, `mm_read`=0, `mm_addr`=0, `mm_burstcount`=0, `st_valid`=0, `st_data`=0.
  - FIFO empty; all counters 0; state IDLE.
- **State machine:** IDLE → ISSUE → DRAIN → IDLE.
- **IDLE:**
  - `st_instruction_ready`=1.
  - On `st_instruction_valid`, latch the address into `addr`, the count into `tx_rem` and `rx_rem`, then go to ISSUE.
  - `st_instruction_ready` is 0 in every other state.
- **ISSUE:**
  - `len = min(tx_rem, MAX_BURST)`.
  - `credit = FIFO_DEPTH - fifo_count - outstanding`.
  - When `mm_read`=0 and `credit >= len`, register `mm_read`=1, `mm_addr={addr,5'b0}`, `mm_burstcount=len`.
  - While `mm_waitrequest`=1, hold `mm_read`, `mm_addr` and `mm_burstcount` stable.
  - On acceptance (`mm_read && !mm_waitrequest`):
    - deassert `mm_read` next cycle;
    - `addr += len`;
    - `tx_rem -= len`;
    - `outstanding += len`.
    - If the new `tx_rem`=0, go to DRAIN.
- **DRAIN:** go to IDLE when `rx_rem`=0 (all words returned). Words may still sit in the FIFO; the next instruction is accepted regardless.
- **Return path:**
  - Each `mm_readdatavalid` with `outstanding>0` pushes `mm_readdata` into the FIFO and decrements `outstanding` and `rx_rem`.
  - `mm_readdatavalid` with `outstanding`=0 is ignored; this covers stale data after reset.
  - If a burst is accepted and a word returns in the same cycle, the net `outstanding` change is `len-1`.
- **Stream output:**
  - `st_valid` = FIFO non-empty; `st_data` = FIFO head.
  - Pop on `st_valid && st_ready`.
  - Push and pop in the same cycle leaves `fifo_count` unchanged.
- **Arithmetic and full/empty:**
  - `addr` is 22 bits and wraps modulo 2^22; no fault.
  - Counters are sized for 1024 words.
  - FIFO overflow is impossible by the credit rule; the bench asserts on it.

## Timing
- Instruction handshake in cycle N → `mm_read` first high at N+2 (state register, then request register) when credit allows.
- `mm_readdatavalid` at cycle M → `st_valid` high at M+1 (registered FIFO).
- Back-to-back bursts: at most 1 idle cycle of `mm_read` between accepted bursts.
- Reset asserted mid-operation:
  - all outputs return to reset values immediately;
  - FIFO contents are discarded;
  - in-flight returns are dropped.

## Configuration
- `SDRAM_READ_ST_LAST_EN` defined:
  - adds output `st_last` (1 bit), reset 0;
  - the FIFO is 257 bits wide;
  - a word is tagged last when pushed with `rx_rem`=1;
  - `st_last`=1 together with `st_valid` on the final word of each instruction.
- Undefined: no `st_last` port; the FIFO is 256 bits wide.

## Test plan
- **Single word:**
  - Stimulus: instruction `{22'h000010, 10'd1}`, no wait.
  - Response: one `mm_read` with `mm_addr`=27'h200 and `mm_burstcount`=1; data `0xAA..` appears on `st_data` one cycle after `mm_readdatavalid`.
- **Multi-burst:**
  - Stimulus: count 20 with `MAX_BURST`=8.
  - Response: bursts of 8/8/4 at word addresses A, A+8, A+16; 20 words out in order; then `st_instruction_ready`=1.
- **Waitrequest:**
  - Stimulus: `mm_waitrequest` held high 3 cycles during a request.
  - Response: `mm_addr`/`mm_burstcount` stable across the stall; exactly one burst accepted.
- **Back-pressure:**
  - Stimulus: `st_ready`=0 with count 40 and `FIFO_DEPTH`=16.
  - Response: issuing stalls once 16 words are reserved; no overflow; all 40 words delivered in order after `st_ready`=1.
- **Reset mid-burst:**
  - Stimulus: `reset` low for 1 cycle after 3 of 8 words are returned.
  - Response: outputs at reset values; the remaining 5 `mm_readdatavalid` are ignored; `st_valid` stays 0.
- **Count 0 (1024 words), `SDRAM_READ_ST_LAST_EN` defined:**
  - Response: 128 bursts of 8; `st_last` high only on word 1024.
